// File: rtl/arf_seq_pkg.sv
// rtl/arf_seq_pkg.sv - op codes, register-file control codes and state encoding for arf_sequencer
package arf_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_FETCH = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_JUMP  = 3'd6,
    OP_RSVD  = 3'd7
  } arf_op_e;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  // RegSel is active low: bit0 SP, bit1 AR, bit2 PC
  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [2:0] SEL_SP   = 3'b110;
  localparam logic [2:0] SEL_PC   = 3'b011;
  localparam logic [2:0] SEL_ALL  = 3'b000;

  typedef enum logic [1:0] {
    OUT_PC = 2'b00,
    OUT_AR = 2'b10,
    OUT_SP = 2'b11
  } arf_outsel_e;

  localparam logic [1:0] ISEL_TARGET = 2'b00;
  localparam logic [1:0] ISEL_MEM    = 2'b01;
  localparam logic [1:0] ISEL_INIT   = 2'b10;

  typedef enum logic [3:0] {
    S_BOOT, S_INIT_CLR, S_INIT_SP, S_IDLE,
    S_ADDR, S_MEM, S_INC, S_DEC, S_LOAD, S_FIN
  } arf_state_e;

  function automatic logic is_grow(arf_op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  function automatic logic is_shrink(arf_op_e op);
    return (op == OP_POP) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/arf_seq_depth.sv
// rtl/arf_seq_depth.sv - stack depth counter with full/empty flags
// Only instantiated when ARF_SEQ_STACK_CHECK_EN is defined.
module arf_seq_depth #(
  parameter int DEPTH = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int W = $clog2(DEPTH + 1);

  logic [W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end else if (dec && !empty) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/arf_sequencer.sv
// rtl/arf_sequencer.sv - expands address-level ops into PC/AR/SP register-file control sequences
// Optional stack over/underflow rejection: define ARF_SEQ_STACK_CHECK_EN.
module arf_sequencer
  import arf_seq_pkg::*;
#(
  parameter logic [15:0] SP_INIT     = 16'hFFFF,
  parameter int          STACK_DEPTH = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [2:0] FunSel,
  output logic [2:0] RegSel,
  output logic [1:0] OutCSel,
  output logic [1:0] OutDSel,
  output logic [1:0] i_sel,
  output logic       mem_rd,
  output logic       mem_wr
);

  arf_state_e state, nxt;
  arf_op_e    op, nxt_op;
  logic       nxt_err;
  logic       full, empty;

  // SP_INIT itself is applied by the register file's I-bus mux when i_sel selects it.
`ifdef ARF_SEQ_STACK_CHECK_EN
  arf_seq_depth #(.DEPTH(STACK_DEPTH)) u_depth (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (done && !err && is_grow(op)),
    .dec   (done && !err && is_shrink(op)),
    .full  (full),
    .empty (empty)
  );
  logic unused_params;
  assign unused_params = ^SP_INIT;
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
  logic unused_params;
  assign unused_params = ^{SP_INIT, STACK_DEPTH};
`endif

  always_comb begin
    nxt     = state;
    nxt_op  = op;
    nxt_err = 1'b0;
    case (state)
      S_BOOT:     nxt = S_INIT_CLR;
      S_INIT_CLR: nxt = S_INIT_SP;
      S_INIT_SP:  nxt = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          nxt_op  = arf_op_e'(req_op);
          nxt_err = (is_grow(nxt_op) && full) || (is_shrink(nxt_op) && empty);
          if (nxt_err) begin
            nxt = S_FIN;
          end else begin
            case (nxt_op)
              OP_FETCH, OP_PUSH, OP_CALL: nxt = S_ADDR;
              OP_POP, OP_RET:             nxt = S_INC;
              OP_JUMP:                    nxt = S_LOAD;
              default:                    nxt = S_FIN;
            endcase
          end
        end
      end
      S_ADDR: nxt = S_MEM;
      S_MEM: begin
        case (op)
          OP_FETCH:         nxt = S_INC;
          OP_PUSH, OP_CALL: nxt = S_DEC;
          OP_RET:           nxt = S_LOAD;
          default:          nxt = S_FIN;
        endcase
      end
      // POP/RET pre-increment SP before addressing the stack
      S_INC:   nxt = (op == OP_FETCH) ? S_FIN : S_ADDR;
      S_DEC:   nxt = (op == OP_CALL) ? S_LOAD : S_FIN;
      S_LOAD:  nxt = S_FIN;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear with the state itself.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_BOOT;
      op        <= OP_NOP;
      FunSel    <= FUN_DEC;
      RegSel    <= SEL_NONE;
      OutCSel   <= OUT_PC;
      OutDSel   <= OUT_PC;
      i_sel     <= ISEL_TARGET;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= nxt;
      op        <= nxt_op;
      FunSel    <= FUN_DEC;
      RegSel    <= SEL_NONE;
      OutCSel   <= OUT_PC;
      OutDSel   <= OUT_PC;
      i_sel     <= ISEL_TARGET;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      case (nxt)
        S_INIT_CLR: begin
          FunSel <= FUN_CLR;
          RegSel <= SEL_ALL;
        end
        S_INIT_SP: begin
          FunSel <= FUN_LOAD;
          RegSel <= SEL_SP;
          i_sel  <= ISEL_INIT;
        end
        S_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        // OutC/OutD are registered in the file, so MEM keeps the ADDR selects
        S_ADDR, S_MEM: begin
          OutDSel <= (nxt_op == OP_FETCH) ? OUT_PC : OUT_SP;
          mem_rd  <= (nxt == S_MEM) && !is_grow(nxt_op);
          mem_wr  <= (nxt == S_MEM) && is_grow(nxt_op);
        end
        S_INC: begin
          FunSel <= FUN_INC;
          RegSel <= (nxt_op == OP_FETCH) ? SEL_PC : SEL_SP;
        end
        S_DEC: begin
          FunSel <= FUN_DEC;
          RegSel <= SEL_SP;
        end
        S_LOAD: begin
          FunSel <= FUN_LOAD;
          RegSel <= SEL_PC;
          i_sel  <= (nxt_op == OP_RET) ? ISEL_MEM : ISEL_TARGET;
        end
        S_FIN: begin
          done <= 1'b1;
          err  <= nxt_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// tb/tb_arf_sequencer.sv - randomized scoreboard bench for arf_sequencer driving a behavioural register file
`timescale 1ns/1ps
module tb_arf_sequencer;

`ifdef ARF_SEQ_STACK_CHECK_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 64;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic       req_ready, done, err, busy, mem_rd, mem_wr;
  logic [2:0] FunSel, RegSel;
  logic [1:0] OutCSel, OutDSel, i_sel;

  arf_sequencer #(.SP_INIT(16'hFFFF), .STACK_DEPTH(TB_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .done(done), .err(err), .busy(busy),
    .FunSel(FunSel), .RegSel(RegSel), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .i_sel(i_sel), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 Clock = ~Clock;

  // Behavioural address register file and memory
  logic [15:0] pc, ar, sp, outc, outd, rdata, target;
  logic [15:0] mem [0:65535];
  wire  [15:0] ibus = (i_sel == 2'b00) ? target : (i_sel == 2'b01) ? rdata : 16'hFFFF;

  function automatic logic [15:0] rf_fun(input logic [15:0] r, input logic [2:0] f, input logic [15:0] ib);
    case (f)
      3'b000:  return r - 16'd1;
      3'b001:  return r + 16'd1;
      3'b010:  return ib;
      3'b011:  return 16'h0000;
      default: return r;
    endcase
  endfunction

  function automatic logic [15:0] rf_out(input logic [1:0] s);
    case (s)
      2'b10:   return ar;
      2'b11:   return sp;
      default: return pc;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (!RegSel[0]) sp <= rf_fun(sp, FunSel, ibus);
    if (!RegSel[1]) ar <= rf_fun(ar, FunSel, ibus);
    if (!RegSel[2]) pc <= rf_fun(pc, FunSel, ibus);
    outc <= rf_out(OutCSel);
    outd <= rf_out(OutDSel);
    if (mem_rd) rdata <= mem[outd];
    if (mem_wr) mem[outd] <= outc;
  end

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int checks = 0, failures = 0, n_issued = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Op-level reference model
  typedef struct {
    logic [2:0]  op;
    logic        err;
    int          lat;
    int          start;
    logic [15:0] pc, sp;
    int          n_acc;
    logic        wr;
    logic [15:0] addr, data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_pc, m_sp;
  logic [15:0] m_mem [0:65535];
  int          m_depth;

  int          acc_n = 0;
  logic        acc_wr;
  logic [15:0] acc_addr, acc_data;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (mem_rd || mem_wr) begin
        acc_n++;
        acc_wr   = mem_wr;
        acc_addr = outd;
        acc_data = outc;
      end
      if (err && !done) begin
        checks++; failures++;
        $display("FAIL err_without_done actual=1 required=0");
      end
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("op%0d_latency", e.op), cyc - e.start, e.lat);
          chk($sformatf("op%0d_err", e.op), err, e.err);
          chk($sformatf("op%0d_pc", e.op), pc, e.pc);
          chk($sformatf("op%0d_sp", e.op), sp, e.sp);
          chk($sformatf("op%0d_accesses", e.op), acc_n, e.n_acc);
          if (e.n_acc == 1 && acc_n == 1) begin
            chk($sformatf("op%0d_acc_wr", e.op), acc_wr, e.wr);
            chk($sformatf("op%0d_acc_addr", e.op), acc_addr, e.addr);
            if (e.wr) chk($sformatf("op%0d_wdata", e.op), acc_data, e.data);
          end
        end
        acc_n = 0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (req_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] tgt);
    exp_t e;
    bit   ok;
    bit   rej;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    rej = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
    rej = ((op == 3'd2 || op == 3'd4) && m_depth == TB_DEPTH) ||
          ((op == 3'd3 || op == 3'd5) && m_depth == 0);
`endif
    e.op = op; e.err = rej; e.start = cyc; e.lat = 1;
    e.n_acc = 0; e.wr = 1'b0; e.addr = 16'h0; e.data = 16'h0;
    if (!rej) begin
      case (op)
        3'd1: begin e.lat = 4; e.n_acc = 1; e.addr = m_pc; m_pc = m_pc + 16'd1; end
        3'd2: begin
          e.lat = 4; e.n_acc = 1; e.wr = 1'b1; e.addr = m_sp; e.data = m_pc;
          m_mem[m_sp] = m_pc; m_sp = m_sp - 16'd1; m_depth++;
        end
        3'd3: begin e.lat = 4; m_sp = m_sp + 16'd1; e.n_acc = 1; e.addr = m_sp; m_depth--; end
        3'd4: begin
          e.lat = 5; e.n_acc = 1; e.wr = 1'b1; e.addr = m_sp; e.data = m_pc;
          m_mem[m_sp] = m_pc; m_sp = m_sp - 16'd1; m_pc = tgt; m_depth++;
        end
        3'd5: begin
          e.lat = 5; m_sp = m_sp + 16'd1; e.n_acc = 1; e.addr = m_sp;
          m_pc = m_mem[m_sp]; m_depth--;
        end
        3'd6: begin e.lat = 2; m_pc = tgt; end
        default: e.lat = 1;
      endcase
    end
    e.pc = m_pc; e.sp = m_sp;
    sb.push_back(e);
    n_issued++;
    target = tgt; req_op = op; req_valid = 1'b1;
    @(negedge Clock);
    // noise while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clock);
    chk("drain_scoreboard", sb.size(), 0);
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_reset_outputs"},
        {FunSel, RegSel, OutCSel, OutDSel, i_sel, mem_rd, mem_wr, done, err, req_ready, busy},
        {3'b000, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    Reset = 1'b0;
    @(negedge Clock);
    chk({tag, "_init_clr"}, {RegSel, FunSel, req_ready}, {3'b000, 3'b011, 1'b0});
    @(negedge Clock);
    chk({tag, "_init_sp"}, {RegSel, FunSel, i_sel, req_ready}, {3'b110, 3'b010, 2'b10, 1'b0});
    @(negedge Clock);
    chk({tag, "_ready"}, {req_ready, busy}, {1'b1, 1'b0});
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_sp"}, sp, 16'hFFFF);
    m_pc = 16'h0000; m_sp = 16'hFFFF; m_depth = 0; acc_n = 0;
  endtask

  task automatic random_ops(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bit ok;
        req_valid = 1'b0;
        wait_ready(ok);
        req_valid = 1'b0;
      end
      issue(3'($urandom_range(0, 7)), 16'($urandom));
    end
  endtask

  initial begin
    bit          ok;
    bit          seen;
    logic [15:0] pre_pc, pre_sp, pre_mem;
    target = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]   = 16'($urandom);
      m_mem[i] = mem[i];
    end
    repeat (3) @(negedge Clock);
    check_init("boot");

    issue(3'd6, 16'h0010);
    issue(3'd1, 16'h0000);
    issue(3'd2, 16'h0000);
    issue(3'd3, 16'h0000);
    issue(3'd6, 16'h0020);
    issue(3'd4, 16'h1234);
    issue(3'd5, 16'h0000);
    issue(3'd0, 16'h0000);
    issue(3'd7, 16'h0000);
    random_ops(200);
    drain();

    // Reset during the MEM cycle of a CALL
    wait_ready(ok);
    pre_pc = pc; pre_sp = sp; pre_mem = mem[sp];
    target = 16'hBEEF; req_op = 3'd4; req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_wr) seen = 1'b1;
      else @(negedge Clock);
    end
    chk("abort_reached_mem", seen, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort_strobes", {mem_wr, mem_rd, RegSel}, {1'b0, 1'b0, 3'b111});
    repeat (2) @(negedge Clock);
    chk("abort_pc", pc, pre_pc);
    chk("abort_sp", sp, pre_sp);
    chk("abort_mem", mem[pre_sp], pre_mem);
    check_init("rerun");

    random_ops(100);
    drain();
    chk("done_count", n_done, n_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
